rggen_register_select_unit: RTL and testbench



---
 rtl/rggen_register_select_unit.sv | 149 ++++++++++++++
 tb/tb_rggen_register_select_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rggen_register_select_unit.sv
// Multi-window register select unit: decodes one host access into a one-hot
// register select, waits for the lane ack or a timeout, then returns a response.
module rggen_register_select_unit #(
   parameter int unsigned                                  ADDRESS_WIDTH       = 16,
   parameter int unsigned                                  REGISTERS           = 4,
   parameter logic [REGISTERS*ADDRESS_WIDTH-1:0]           START_ADDRESSES     = '0,
   parameter logic [REGISTERS*ADDRESS_WIDTH-1:0]           END_ADDRESSES       = '0,
   parameter logic [REGISTERS-1:0]                         USE_SHADOW_INDEX    = '0,
   parameter int unsigned                                  SHADOW_INDEX_WIDTH  = 1,
   parameter logic [REGISTERS*SHADOW_INDEX_WIDTH-1:0]      SHADOW_INDEX_VALUES = '0,
   parameter int unsigned                                  TIMEOUT_CYCLES      = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          i_request_valid,
   output logic                          o_request_ready,
   input  logic [ADDRESS_WIDTH-1:0]      i_address,
   input  logic                          i_write,
   input  logic [SHADOW_INDEX_WIDTH-1:0] i_shadow_index,
   output logic [REGISTERS-1:0]          o_select,
   output logic                          o_write,
   input  logic [REGISTERS-1:0]          i_register_ack,
   output logic                          o_response_valid,
   input  logic                          i_response_ready,
   output logic                          o_response_error
);

   localparam int unsigned COUNT_WIDTH  = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned TIMEOUT_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
   localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(TIMEOUT_LAST);
   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = '1;
   localparam bit TIMEOUT_ENABLE = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RESPOND = 2'd2
   } state_e;

   state_e                   r_state, w_state;
   logic                     r_request_ready, w_request_ready;
   logic [REGISTERS-1:0]     r_select, w_select;
   logic                     r_write, w_write;
   logic                     r_response_valid, w_response_valid;
   logic                     r_response_error, w_response_error;
   logic [COUNT_WIDTH-1:0]   r_count, w_count;
   logic [REGISTERS-1:0]     w_match;
   logic [REGISTERS-1:0]     w_decode;

   // Window/shadow match per lane; the inclusive range also covers START==END,
   // and START>END can never satisfy both bounds. Lowest matching lane wins.
   always_comb begin
      w_match = '0;
      for (int i = 0; i < REGISTERS; i++) begin
         w_match[i] = (i_address >= START_ADDRESSES[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]) &&
                      (i_address <= END_ADDRESSES[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]) &&
                      (!USE_SHADOW_INDEX[i] ||
                       (i_shadow_index == SHADOW_INDEX_VALUES[i*SHADOW_INDEX_WIDTH +: SHADOW_INDEX_WIDTH]));
      end
      w_decode = w_match & (~w_match + REGISTERS'(1));
   end

   // Next-state and next-output logic
   always_comb begin
      w_state          = r_state;
      w_request_ready  = r_request_ready;
      w_select         = r_select;
      w_write          = r_write;
      w_response_valid = r_response_valid;
      w_response_error = r_response_error;
      w_count          = r_count;
      case (r_state)
         IDLE: begin
            w_request_ready = 1'b1;
            if (i_request_valid && r_request_ready) begin
               w_request_ready = 1'b0;
               w_write         = i_write;
               w_count         = '0;
               if (w_match != '0) begin
                  w_select = w_decode;
                  w_state  = ACCESS;
               end else begin
                  w_select         = '0;
                  w_response_valid = 1'b1;
                  w_response_error = 1'b1;
                  w_state          = RESPOND;
               end
            end
         end
         ACCESS: begin
            if ((i_register_ack & r_select) != '0) begin
               w_select         = '0;
               w_count          = '0;
               w_response_valid = 1'b1;
               w_response_error = 1'b0;
               w_state          = RESPOND;
            end else if (TIMEOUT_ENABLE && (r_count == COUNT_LAST)) begin
               w_select         = '0;
               w_count          = '0;
               w_response_valid = 1'b1;
               w_response_error = 1'b1;
               w_state          = RESPOND;
            end else if (r_count != COUNT_MAX) begin
               // saturate so a disabled timeout can never wrap the counter
               w_count = r_count + COUNT_WIDTH'(1);
            end
         end
         RESPOND: begin
            if (i_response_ready) begin
               w_response_valid = 1'b0;
               w_response_error = 1'b0;
               w_request_ready  = 1'b1;
               w_state          = IDLE;
            end
         end
         default: begin
            w_state = IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state          <= IDLE;
         r_request_ready  <= 1'b0;
         r_select         <= '0;
         r_write          <= 1'b0;
         r_response_valid <= 1'b0;
         r_response_error <= 1'b0;
         r_count          <= '0;
      end else begin
         r_state          <= w_state;
         r_request_ready  <= w_request_ready;
         r_select         <= w_select;
         r_write          <= w_write;
         r_response_valid <= w_response_valid;
         r_response_error <= w_response_error;
         r_count          <= w_count;
      end
   end

   assign o_request_ready  = r_request_ready;
   assign o_select         = r_select;
   assign o_write          = r_write;
   assign o_response_valid = r_response_valid;
   assign o_response_error = r_response_error;

endmodule

// File: tb/tb_rggen_register_select_unit.sv
// Directed bench for rggen_register_select_unit: an 8-lane instance with a
// 4-cycle timeout and a 1-lane instance with the timeout disabled.
module tb_rggen_register_select_unit;

   logic        clk;
   logic        rst_n;

   logic        req_valid, req_ready;
   logic [15:0] address;
   logic        write;
   logic [1:0]  shadow_index;
   logic [7:0]  sel;
   logic        o_wr;
   logic [7:0]  ack;
   logic        resp_valid, resp_ready, resp_error;

   logic        b_req_valid, b_req_ready;
   logic [15:0] b_address;
   logic        b_write;
   logic [0:0]  b_shadow_index;
   logic [0:0]  b_sel;
   logic        b_o_wr;
   logic [0:0]  b_ack;
   logic        b_resp_valid, b_resp_ready, b_resp_error;

   int checks = 0;
   int errors = 0;
   bit exp_err_q[$];

   // lane7..lane0: never(0x40>0x3F), 0x00, 0x20, 0x20, 0x10, 0x08-0x0F, 0x04(idx2), 0x04(idx1)
   rggen_register_select_unit #(
      .ADDRESS_WIDTH      (16),
      .REGISTERS          (8),
      .START_ADDRESSES    ({16'h0040, 16'h0000, 16'h0020, 16'h0020, 16'h0010, 16'h0008, 16'h0004, 16'h0004}),
      .END_ADDRESSES      ({16'h003F, 16'h0000, 16'h0020, 16'h0020, 16'h0010, 16'h000F, 16'h0004, 16'h0004}),
      .USE_SHADOW_INDEX   (8'b0000_0011),
      .SHADOW_INDEX_WIDTH (2),
      .SHADOW_INDEX_VALUES(16'h0009),
      .TIMEOUT_CYCLES     (4)
   ) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_request_valid  (req_valid),
      .o_request_ready  (req_ready),
      .i_address        (address),
      .i_write          (write),
      .i_shadow_index   (shadow_index),
      .o_select         (sel),
      .o_write          (o_wr),
      .i_register_ack   (ack),
      .o_response_valid (resp_valid),
      .i_response_ready (resp_ready),
      .o_response_error (resp_error)
   );

   rggen_register_select_unit #(
      .ADDRESS_WIDTH      (16),
      .REGISTERS          (1),
      .START_ADDRESSES    (16'h0100),
      .END_ADDRESSES      (16'h01FF),
      .USE_SHADOW_INDEX   (1'b0),
      .SHADOW_INDEX_WIDTH (1),
      .SHADOW_INDEX_VALUES(1'b0),
      .TIMEOUT_CYCLES     (0)
   ) u_dut_nto (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_request_valid  (b_req_valid),
      .o_request_ready  (b_req_ready),
      .i_address        (b_address),
      .i_write          (b_write),
      .i_shadow_index   (b_shadow_index),
      .o_select         (b_sel),
      .o_write          (b_o_wr),
      .i_register_ack   (b_ack),
      .o_response_valid (b_resp_valid),
      .i_response_ready (b_resp_ready),
      .o_response_error (b_resp_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_request(input string tag, input logic [15:0] addr, input logic wr,
                             input logic [1:0] idx, input logic [7:0] exp_sel);
      int n = 0;
      while (!req_ready && n < 50) begin
         tick();
         n++;
      end
      check({tag, "/ready"}, 32'(req_ready), 32'h1);
      req_valid    = 1'b1;
      address      = addr;
      write        = wr;
      shadow_index = idx;
      exp_err_q.push_back(exp_sel == 8'h00);
      tick();
      req_valid = 1'b0;
      check({tag, "/select"}, 32'(sel), 32'(exp_sel));
      check({tag, "/ready_low"}, 32'(req_ready), 32'h0);
      if (exp_sel != 8'h00) check({tag, "/write"}, 32'(o_wr), 32'(wr));
   endtask

   task automatic get_response(input string tag, input int stall);
      int n = 0;
      bit exp;
      while (!resp_valid && n < 50) begin
         tick();
         n++;
      end
      check({tag, "/resp_valid"}, 32'(resp_valid), 32'h1);
      exp = (exp_err_q.size() > 0) ? exp_err_q.pop_front() : 1'b0;
      check({tag, "/resp_error"}, 32'(resp_error), 32'(exp));
      for (int i = 0; i < stall; i++) begin
         tick();
         check({tag, "/hold_valid"}, 32'(resp_valid), 32'h1);
         check({tag, "/hold_error"}, 32'(resp_error), 32'(exp));
         check({tag, "/hold_select"}, 32'(sel), 32'h0);
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check({tag, "/valid_drop"}, 32'(resp_valid), 32'h0);
      check({tag, "/ready_back"}, 32'(req_ready), 32'h1);
   endtask

   task automatic run_access(input string tag, input logic [15:0] addr, input logic wr,
                             input logic [1:0] idx, input logic [7:0] exp_sel);
      do_request(tag, addr, wr, idx, exp_sel);
      if (exp_sel != 8'h00) begin
         ack = exp_sel;
         tick();
         ack = 8'h00;
      end
      get_response(tag, 0);
   endtask

   initial begin
      bit b_exp;
      int n;
      rst_n = 1'b0;
      req_valid = 1'b0; address = '0; write = 1'b0; shadow_index = '0; ack = '0; resp_ready = 1'b0;
      b_req_valid = 1'b0; b_address = '0; b_write = 1'b0; b_shadow_index = '0; b_ack = '0; b_resp_ready = 1'b0;

      // reset state
      repeat (3) tick();
      check("rst/ready", 32'(req_ready), 32'h0);
      check("rst/select", 32'(sel), 32'h0);
      check("rst/write", 32'(o_wr), 32'h0);
      check("rst/resp_valid", 32'(resp_valid), 32'h0);
      check("rst/resp_error", 32'(resp_error), 32'h0);
      rst_n = 1'b1;
      check("rst/ready_before_edge", 32'(req_ready), 32'h0);
      tick();
      check("rst/ready_after_edge", 32'(req_ready), 32'h1);

      // mapped write, non-selected ack ignored, then selected ack
      do_request("wr", 16'h000A, 1'b1, 2'd0, 8'h04);
      ack = 8'h01;
      tick();
      ack = 8'h00;
      check("wr/foreign_ack_select", 32'(sel), 32'h04);
      check("wr/foreign_ack_valid", 32'(resp_valid), 32'h0);
      ack = 8'h04;
      tick();
      ack = 8'h00;
      check("wr/ack_select_clear", 32'(sel), 32'h0);
      get_response("wr", 0);

      // unmapped read with response backpressure
      do_request("unmapped", 16'h0030, 1'b0, 2'd0, 8'h00);
      get_response("unmapped", 3);

      // window boundaries, shadow qualification, overlap priority, START>END
      run_access("lo_edge", 16'h0008, 1'b0, 2'd0, 8'h04);
      run_access("hi_edge", 16'h000F, 1'b1, 2'd0, 8'h04);
      run_access("below", 16'h0007, 1'b0, 2'd0, 8'h00);
      run_access("above", 16'h0011, 1'b0, 2'd0, 8'h00);
      run_access("zero", 16'h0000, 1'b0, 2'd0, 8'h40);
      run_access("shadow2", 16'h0004, 1'b0, 2'd2, 8'h02);
      run_access("shadow1", 16'h0004, 1'b1, 2'd1, 8'h01);
      run_access("shadow3", 16'h0004, 1'b0, 2'd3, 8'h00);
      run_access("overlap", 16'h0020, 1'b1, 2'd0, 8'h10);
      run_access("inverted", 16'h0040, 1'b0, 2'd0, 8'h00);
      run_access("inverted_lo", 16'h003F, 1'b0, 2'd0, 8'h00);

      // timeout: select held exactly 4 cycles then error response
      do_request("timeout", 16'h0010, 1'b0, 2'd0, 8'h08);
      void'(exp_err_q.pop_back());
      exp_err_q.push_back(1'b1);
      n = 0;
      while (sel != 8'h00 && n < 50) begin
         n++;
         tick();
      end
      check("timeout/select_cycles", 32'(n), 32'd4);
      get_response("timeout", 0);

      // ack on the final timeout cycle wins
      do_request("ack_last", 16'h0010, 1'b1, 2'd0, 8'h08);
      repeat (3) tick();
      check("ack_last/still_selected", 32'(sel), 32'h08);
      ack = 8'h08;
      tick();
      ack = 8'h00;
      get_response("ack_last", 0);

      // asynchronous reset during access aborts without a response
      do_request("abort", 16'h0010, 1'b0, 2'd0, 8'h08);
      void'(exp_err_q.pop_back());
      rst_n = 1'b0;
      #1;
      check("abort/select", 32'(sel), 32'h0);
      check("abort/resp_valid", 32'(resp_valid), 32'h0);
      check("abort/ready", 32'(req_ready), 32'h0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      check("abort/ready_back", 32'(req_ready), 32'h1);
      check("abort/no_response", 32'(resp_valid), 32'h0);

      // disabled timeout: ack after 100 cycles still completes without error
      n = 0;
      while (!b_req_ready && n < 50) begin
         tick();
         n++;
      end
      check("nto/ready", 32'(b_req_ready), 32'h1);
      b_req_valid = 1'b1;
      b_address   = 16'h0150;
      b_write     = 1'b1;
      exp_err_q.push_back(1'b0);
      tick();
      b_req_valid = 1'b0;
      check("nto/select", 32'(b_sel), 32'h1);
      check("nto/write", 32'(b_o_wr), 32'h1);
      repeat (100) tick();
      check("nto/select_held", 32'(b_sel), 32'h1);
      check("nto/no_response", 32'(b_resp_valid), 32'h0);
      b_ack = 1'b1;
      tick();
      b_ack = 1'b0;
      check("nto/resp_valid", 32'(b_resp_valid), 32'h1);
      b_exp = (exp_err_q.size() > 0) ? exp_err_q.pop_front() : 1'b1;
      check("nto/resp_error", 32'(b_resp_error), 32'(b_exp));
      b_resp_ready = 1'b1;
      tick();
      b_resp_ready = 1'b0;
      check("nto/valid_drop", 32'(b_resp_valid), 32'h0);
      check("nto/ready_back", 32'(b_req_ready), 32'h1);

      check("scoreboard/empty", 32'(exp_err_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
